dff_bank_sequencer: RTL and testbench

DFF_BANK_SEQUENCER -- requirements
Module: dff_bank_sequencer

---
 rtl/dff_seq_pkg.sv | 20 ++
 rtl/sat_cnt8.sv | 34 +++
 rtl/dff_bank_sequencer.sv | 139 +++++++++++++
 tb/tb_dff_bank_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_seq_pkg.sv
// rtl/dff_seq_pkg.sv - shared state encoding and constants for the flop-bank sequencer
package dff_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT,
    S_DONE
  } state_e;

  // bit positions of the stimulus vector taken from step_o[2:0]
  localparam int VEC_D  = 0;
  localparam int VEC_EN = 1;
  localparam int VEC_SR = 2;

  localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/sat_cnt8.sv
// rtl/sat_cnt8.sv - 8-bit saturating counter with clear (priority) and increment
module sat_cnt8
  import dff_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != ERR_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dff_bank_sequencer.sv
// rtl/dff_bank_sequencer.sv - steps a flop bank through all d/en/sr vectors,
// samples q after a settle delay and reports each step over a valid/ready handshake
module dff_bank_sequencer
  import dff_seq_pkg::*;
#(
  parameter int WIDTH  = 48,
  parameter int SETTLE = 2,
  parameter int PASSES = 2,
  localparam int STEPS = 8 * PASSES,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             d_o,
  output logic             en_o,
  output logic             sr_o,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] exp_i,
  output logic [SW-1:0]    step_o,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [WIDTH-1:0] rpt_q,
  output logic [SW-1:0]    rpt_step,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt
);

  localparam logic [3:0]    SETTLE_L = 4'(SETTLE);
  localparam logic [SW-1:0] LAST     = SW'(STEPS - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rpt_q_q, rpt_q_d;
  logic [SW-1:0]    rpt_step_q, rpt_step_d;
  logic             pass_q, pass_d;
  logic             err_clr, err_inc;
  logic             stim_active;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    rpt_q_d    = rpt_q_q;
    rpt_step_d = rpt_step_q;
    pass_d     = pass_q;
    err_clr    = 1'b0;
    err_inc    = 1'b0;
    // start is only honoured in IDLE, where it also outranks abort
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_APPLY;
        step_d  = '0;
        err_clr = 1'b1;
        pass_d  = 1'b0;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_APPLY: begin
          cnt_d   = SETTLE_L;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q <= 4'd1) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          rpt_q_d    = q_i;
          rpt_step_d = step_q;
          err_inc    = (q_i != exp_i);
          state_d    = S_REPORT;
        end
        S_REPORT: begin
          if (rpt_ready) begin
            if (step_q == LAST) begin
              state_d = S_DONE;
              pass_d  = (err_cnt == 8'd0);
            end else begin
              step_d  = step_q + 1'b1;
              state_d = S_APPLY;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      rpt_q_q    <= '0;
      rpt_step_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      rpt_q_q    <= rpt_q_d;
      rpt_step_q <= rpt_step_d;
      pass_q     <= pass_d;
    end
  end

  sat_cnt8 u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign stim_active = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                       (state_q == S_SAMPLE) || (state_q == S_REPORT);

  assign d_o       = stim_active & step_q[VEC_D];
  assign en_o      = stim_active & step_q[VEC_EN];
  assign sr_o      = stim_active & step_q[VEC_SR];
  assign step_o    = step_q;
  assign rpt_valid = (state_q == S_REPORT);
  assign rpt_q     = rpt_q_q;
  assign rpt_step  = rpt_step_q;
  assign busy      = stim_active;
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;

endmodule

// File: tb/tb_dff_bank_sequencer.sv
// tb/tb_dff_bank_sequencer.sv - scoreboard bench for dff_bank_sequencer with a behavioural flop bank
module tb_dff_bank_sequencer;

  localparam int WIDTH   = 48;
  localparam int SETTLE  = 2;
  localparam int PASSES  = 2;
  localparam int STEPS   = 16;
  localparam int SW      = 4;
  localparam int RUN_CYC = STEPS * (SETTLE + 3) + 1;
  localparam logic [WIDTH-1:0] PAT = 48'hA5A5_5A5A_F00F;

  localparam int W2    = 8;
  localparam int SW2   = 5;
  localparam int RUN2  = 32 * (1 + 3) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, abort, rpt_ready;
  logic             d_o, en_o, sr_o, rpt_valid, busy, done, pass;
  logic [WIDTH-1:0] q_i, exp_i, rpt_q, bank_q;
  logic [SW-1:0]    step_o, rpt_step;
  logic [7:0]       err_cnt;
  int               flip_mode;

  logic             start2, d2, en2, sr2, valid2, busy2, done2, pass2;
  logic [W2-1:0]    bank2_q, rpt_q2;
  logic [SW2-1:0]   step2, rpt_step2;
  logic [7:0]       err2;

  logic             sc_clr, sc_inc;
  logic [7:0]       sc_cnt;

  typedef struct {
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] q;
  } rpt_t;
  rpt_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_rpt = 0;

  dff_bank_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .PASSES(PASSES)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .d_o(d_o), .en_o(en_o), .sr_o(sr_o), .q_i(q_i), .exp_i(exp_i),
    .step_o(step_o), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_q(rpt_q), .rpt_step(rpt_step), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt)
  );

  dff_bank_sequencer #(.WIDTH(W2), .SETTLE(1), .PASSES(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .d_o(d2), .en_o(en2), .sr_o(sr2), .q_i(bank2_q), .exp_i(~bank2_q),
    .step_o(step2), .rpt_valid(valid2), .rpt_ready(1'b1),
    .rpt_q(rpt_q2), .rpt_step(rpt_step2), .busy(busy2), .done(done2),
    .pass(pass2), .err_cnt(err2)
  );

  sat_cnt8 u_sat (.clk(clk), .rst(rst), .clr(sc_clr), .inc(sc_inc), .cnt(sc_cnt));

  // behavioural flop banks: sync reset wins over enable; d picks PAT or its inverse
  always @(posedge clk or posedge rst) begin
    if (rst)       bank_q <= '0;
    else if (sr_o) bank_q <= '0;
    else if (en_o) bank_q <= d_o ? PAT : ~PAT;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)      bank2_q <= '0;
    else if (sr2) bank2_q <= '0;
    else if (en2) bank2_q <= d2 ? 8'h5A : 8'hA5;
  end

  assign q_i = bank_q;

  function automatic logic [WIDTH-1:0] model_q(input int s);
    case (s % 8)
      2:       return ~PAT;
      3:       return PAT;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    exp_i = model_q(int'(step_o));
    if (flip_mode == 1 && (step_o == 4'd3 || step_o == 4'd9)) exp_i[5] = ~exp_i[5];
  end

  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      n_cmp++;
      n_rpt++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: unexpected report step=%0d q=%h", rpt_step, rpt_q);
      end else begin
        rpt_t e;
        e = sb.pop_front();
        if (rpt_step !== e.step || rpt_q !== e.q) begin
          n_bad++;
          $display("FAIL sb_report: got step=%0d q=%h, want step=%0d q=%h",
                   rpt_step, rpt_q, e.step, e.q);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int s = 0; s < STEPS; s++) begin
      rpt_t e;
      e.step = SW'(s);
      e.q    = model_q(s);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // kind 0: step_o == val, 1: rpt_valid, 2: done
  task automatic wait_for(input int kind, input int val, input string name, output int cyc);
    bit hit;
    cyc = 0;
    hit = 0;
    while (!hit && cyc < 500) begin
      case (kind)
        0:       hit = (int'(step_o) == val);
        1:       hit = rpt_valid;
        default: hit = done;
      endcase
      if (!hit) begin
        tick();
        cyc++;
      end
    end
    if (!hit) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles", name, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 0; abort = 0; rpt_ready = 1; flip_mode = 0;
    start2 = 0; sc_clr = 0; sc_inc = 0;
    tick();
    tick();
    n_cmp++;
    if ({sr_o, en_o, d_o} !== 3'b000) begin n_bad++; $display("FAIL reset_stim: got %b want 000", {sr_o, en_o, d_o}); end
    n_cmp++;
    if ({busy, done, pass, rpt_valid} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, rpt_valid}); end
    n_cmp++;
    if (step_o !== '0 || rpt_step !== '0) begin n_bad++; $display("FAIL reset_steps: got %0d/%0d want 0/0", step_o, rpt_step); end
    n_cmp++;
    if (rpt_q !== '0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_data: got q=%h err=%0d want 0/0", rpt_q, err_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    int cyc;
    flip_mode = 0;
    n_rpt = 0;
    push_run();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || step_o !== '0) begin n_bad++; $display("FAIL run_first: busy=%b step=%0d want 1/0", busy, step_o); end
    wait_for(2, 0, "run_done_wait", cyc);
    n_cmp++;
    if (cyc + 1 != RUN_CYC) begin n_bad++; $display("FAIL run_latency: done at cycle %0d want %0d", cyc + 1, RUN_CYC); end
    n_cmp++;
    if (pass !== 1'b1 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL run_result: pass=%b err=%0d want 1/0", pass, err_cnt); end
    n_cmp++;
    if (n_rpt != STEPS || sb.size() != 0) begin n_bad++; $display("FAIL run_reports: got %0d left %0d want %0d/0", n_rpt, sb.size(), STEPS); end
    tick();
    n_cmp++;
    if ({busy, done, pass} !== 3'b001) begin n_bad++; $display("FAIL run_after: busy/done/pass=%b want 001", {busy, done, pass}); end
  endtask

  task automatic test_mismatch();
    int cyc;
    flip_mode = 1;
    push_run();
    pulse_start();
    wait_for(2, 0, "mis_done_wait", cyc);
    n_cmp++;
    if (err_cnt !== 8'd2 || pass !== 1'b0) begin n_bad++; $display("FAIL mismatch: err=%0d pass=%b want 2/0", err_cnt, pass); end
    flip_mode = 0;
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit hold_ok;
    push_run();
    pulse_start();
    wait_for(0, 4, "bp_step4_wait", cyc);
    rpt_ready = 1'b0;
    wait_for(1, 0, "bp_valid_wait", cyc);
    hold_ok = 1;
    repeat (10) begin
      if (!(rpt_valid === 1'b1 && rpt_step === 4'd4 && rpt_q === model_q(4) &&
            {sr_o, en_o, d_o} === 3'b100 && step_o === 4'd4)) hold_ok = 0;
      tick();
    end
    n_cmp++;
    if (hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %b want 1 (valid=%b step=%0d)", hold_ok, rpt_valid, step_o); end
    rpt_ready = 1'b1;
    tick();
    n_cmp++;
    if (step_o !== 4'd5 || rpt_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: step=%0d valid=%b want 5/0", step_o, rpt_valid); end
    wait_for(2, 0, "bp_done_wait", cyc);
    n_cmp++;
    if (pass !== 1'b1) begin n_bad++; $display("FAIL bp_pass: got %b want 1", pass); end
    tick();
  endtask

  task automatic test_abort();
    int cyc;
    bit done_seen;
    flip_mode = 1;
    push_run();
    pulse_start();
    wait_for(0, 7, "ab_step7_wait", cyc);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({busy, rpt_valid, pass, sr_o, en_o, d_o} !== 6'b000000) begin
      n_bad++; $display("FAIL abort_idle: busy/valid/pass/stim=%b want 000000", {busy, rpt_valid, pass, sr_o, en_o, d_o});
    end
    n_cmp++;
    if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL abort_err: got %0d want 1", err_cnt); end
    done_seen = 0;
    repeat (5) begin
      if (done) done_seen = 1;
      tick();
    end
    n_cmp++;
    if (done_seen !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done_seen); end
    sb.delete();
    flip_mode = 0;
    push_run();
    pulse_start();
    n_cmp++;
    if (step_o !== 4'd0 || err_cnt !== 8'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_restart: step=%0d err=%0d busy=%b want 0/0/1", step_o, err_cnt, busy); end
    wait_for(2, 0, "ab_done_wait", cyc);
    n_cmp++;
    if (pass !== 1'b1) begin n_bad++; $display("FAIL abort_rerun_pass: got %b want 1", pass); end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    flip_mode = 1;
    push_run();
    pulse_start();
    wait_for(0, 2, "rm_step2_wait", cyc);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    n_cmp++;
    if (step_o !== 4'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL busy_start: step=%0d busy=%b want 2/1", step_o, busy); end
    wait_for(0, 5, "rm_step5_wait", cyc);
    rpt_ready = 1'b0;
    wait_for(1, 0, "rm_valid_wait", cyc);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sr_o, en_o, d_o, busy, done, pass, rpt_valid} !== 7'b0) begin
      n_bad++; $display("FAIL rst_async_flags: got %b want 0000000", {sr_o, en_o, d_o, busy, done, pass, rpt_valid});
    end
    n_cmp++;
    if (step_o !== '0 || rpt_step !== '0 || rpt_q !== '0 || err_cnt !== 8'd0) begin
      n_bad++; $display("FAIL rst_async_data: step=%0d rstep=%0d q=%h err=%0d want all 0", step_o, rpt_step, rpt_q, err_cnt);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rpt_ready = 1'b1;
    flip_mode = 0;
    tick();
  endtask

  task automatic test_saturation();
    int cyc;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 600) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc != RUN2) begin n_bad++; $display("FAIL p4_latency: done at cycle %0d want %0d", cyc, RUN2); end
    n_cmp++;
    if (err2 !== 8'd32 || pass2 !== 1'b0) begin n_bad++; $display("FAIL p4_err: err=%0d pass=%b want 32/0", err2, pass2); end
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    sc_inc = 1'b1;
    repeat (254) tick();
    n_cmp++;
    if (sc_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", sc_cnt); end
    repeat (46) tick();
    n_cmp++;
    if (sc_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_300: got %0d want 255", sc_cnt); end
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    n_cmp++;
    if (sc_cnt !== 8'd0) begin n_bad++; $display("FAIL sat_clear: got %0d want 0", sc_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_run();
    test_mismatch();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_full_run();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
